// File: rtl/fm_sb_pkg.sv
// Shared types and default sizing for the spy-buffer freeze sequencer.
package fm_sb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } state_t;

  localparam int SB_N_DEF  = 27;
  localparam int CNT_W_DEF = 16;
  localparam int PB_W_DEF  = 2;

endpackage

// File: rtl/fm_freeze_seq_if.sv
// Control/status bundle between a host (master) and the freeze sequencer (slave).
// The unfreeze/abort pulse is called release_req because "release" is a keyword.
interface fm_freeze_seq_if #(
  parameter int SB_N  = fm_sb_pkg::SB_N_DEF,
  parameter int CNT_W = fm_sb_pkg::CNT_W_DEF,
  parameter int PB_W  = fm_sb_pkg::PB_W_DEF
) ();
  import fm_sb_pkg::*;

  logic             arm;
  logic             release_req;
  logic             sw_trig;
  logic             trig_ext;
  logic [CNT_W-1:0] post_count;
  logic [SB_N-1:0]  sb_mask;
  logic [PB_W-1:0]  pb_mode_req;

  logic [SB_N-1:0]  freeze;
  logic [PB_W-1:0]  playback_mode;
  state_t           state;
  logic             busy;
  logic [CNT_W-1:0] trig_cnt;
  logic [CNT_W-1:0] miss_cnt;

  modport master (
    output arm, release_req, sw_trig, trig_ext, post_count, sb_mask, pb_mode_req,
    input  freeze, playback_mode, state, busy, trig_cnt, miss_cnt
  );

  modport slave (
    input  arm, release_req, sw_trig, trig_ext, post_count, sb_mask, pb_mode_req,
    output freeze, playback_mode, state, busy, trig_cnt, miss_cnt
  );

endinterface

// File: rtl/fm_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module fm_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Clear has priority over increment; increment stops at the maximum value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/fm_freeze_seq.sv
// Freeze sequencer: arm, wait for a trigger, keep capturing for post_count
// cycles, then freeze the selected spy buffers until released or re-armed.
module fm_freeze_seq
  import fm_sb_pkg::*;
#(
  parameter int SB_N  = SB_N_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int PB_W  = PB_W_DEF
) (
  input logic            clk_hs,
  input logic            rst_hs,
  fm_freeze_seq_if.slave bus
);

  state_t           state_q;
  state_t           state_nxt;
  logic             trig_d;
  logic             trig_evt;
  logic [SB_N-1:0]  mask_q;
  logic [SB_N-1:0]  freeze_q;
  logic [CNT_W-1:0] post_q;
  logic [CNT_W-1:0] down_q;
  logic [PB_W-1:0]  pb_q;
  logic             busy_q;
  logic             trig_acc;
  logic             trig_miss;
  logic             cnt_clr;
  logic             relatch;

  // A trigger is a software pulse or a fresh rising edge on the external level.
  assign trig_evt  = bus.sw_trig | (bus.trig_ext & ~trig_d);
  assign trig_acc  = trig_evt && (state_q == ST_ARMED) && !bus.release_req;
  assign trig_miss = trig_evt && ((state_q == ST_POST) || (state_q == ST_FROZEN));
  assign cnt_clr   = bus.arm && !bus.release_req && (state_q == ST_IDLE);
  assign relatch   = bus.arm && !bus.release_req &&
                     ((state_q == ST_IDLE) || (state_q == ST_FROZEN));

  // Next-state decision; release overrides everything including arm.
  always_comb begin
    state_nxt = state_q;
    if (bus.release_req) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (bus.arm) state_nxt = ST_ARMED;
        ST_ARMED:  if (trig_evt) state_nxt = (post_q == '0) ? ST_FROZEN : ST_POST;
        ST_POST:   if (down_q <= CNT_W'(1)) state_nxt = ST_FROZEN;
        ST_FROZEN: if (bus.arm) state_nxt = ST_ARMED;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, latched configuration, down-counter and registered outputs.
  always_ff @(posedge clk_hs or posedge rst_hs) begin
    if (rst_hs) begin
      state_q  <= ST_IDLE;
      trig_d   <= 1'b1;
      mask_q   <= '0;
      post_q   <= '0;
      down_q   <= '0;
      freeze_q <= '0;
      pb_q     <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      trig_d   <= bus.trig_ext;
      busy_q   <= (state_nxt == ST_ARMED) || (state_nxt == ST_POST);
      freeze_q <= (state_nxt == ST_FROZEN) ? mask_q : '0;
      if (state_q == ST_IDLE) begin
        pb_q <= bus.pb_mode_req;
      end
      if (relatch) begin
        mask_q <= bus.sb_mask;
        post_q <= bus.post_count;
      end
      if (state_nxt == ST_POST) begin
        down_q <= (state_q == ST_POST) ? (down_q - CNT_W'(1)) : post_q;
      end else begin
        down_q <= '0;
      end
    end
  end

  fm_sat_cnt #(.W(CNT_W)) u_trig_cnt (
    .clk (clk_hs),
    .rst (rst_hs),
    .clr (cnt_clr),
    .inc (trig_acc),
    .cnt (bus.trig_cnt)
  );

  fm_sat_cnt #(.W(CNT_W)) u_miss_cnt (
    .clk (clk_hs),
    .rst (rst_hs),
    .clr (cnt_clr),
    .inc (trig_miss),
    .cnt (bus.miss_cnt)
  );

  assign bus.state         = state_q;
  assign bus.freeze        = freeze_q;
  assign bus.playback_mode = pb_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_fm_freeze_seq.sv
// Directed bench for fm_freeze_seq: a full-size instance for sequencing and a
// 4-bit-counter instance for saturation, both sharing clock and reset.
module tb_fm_freeze_seq;

  logic clk_hs;
  logic rst_hs;
  int   n_checks;
  int   n_pass;
  logic saw_freeze;

  fm_freeze_seq_if #(.SB_N(27), .CNT_W(16), .PB_W(2)) bus ();
  fm_freeze_seq_if #(.SB_N(4),  .CNT_W(4),  .PB_W(2)) sif ();

  fm_freeze_seq #(.SB_N(27), .CNT_W(16), .PB_W(2)) dut (
    .clk_hs (clk_hs),
    .rst_hs (rst_hs),
    .bus    (bus)
  );

  fm_freeze_seq #(.SB_N(4), .CNT_W(4), .PB_W(2)) dut_sat (
    .clk_hs (clk_hs),
    .rst_hs (rst_hs),
    .bus    (sif)
  );

  // Free-running 10 ns clock.
  initial clk_hs = 1'b0;
  always #5 clk_hs = ~clk_hs;

  // Single comparison point; every check is counted here.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_hs);
    #1;
  endtask

  // Drive one cycle of pulse inputs on the main instance, then drop them.
  task automatic applyStimulus(input logic a, input logic r, input logic s);
    bus.arm         = a;
    bus.release_req = r;
    bus.sw_trig     = s;
    tick();
    bus.arm         = 1'b0;
    bus.release_req = 1'b0;
    bus.sw_trig     = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    bus.arm = 0; bus.release_req = 0; bus.sw_trig = 0; bus.trig_ext = 0;
    bus.post_count = '0; bus.sb_mask = '0; bus.pb_mode_req = 2'd2;
    sif.arm = 0; sif.release_req = 0; sif.sw_trig = 0; sif.trig_ext = 0;
    sif.post_count = '0; sif.sb_mask = '0; sif.pb_mode_req = 2'd0;

    // Reset state
    rst_hs = 1'b1;
    repeat (2) tick();
    checkOutput("rst_state", bus.state, 0);
    checkOutput("rst_freeze", bus.freeze, 0);
    checkOutput("rst_pb", bus.playback_mode, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_trig", bus.trig_cnt, 0);
    checkOutput("rst_miss", bus.miss_cnt, 0);
    rst_hs = 1'b0;
    tick();
    checkOutput("idle_pb_load", bus.playback_mode, 2);

    // Post-trigger latency with post_count=5
    bus.sb_mask = 27'h7FFFFFF; bus.post_count = 16'd5;
    applyStimulus(1, 0, 0);
    checkOutput("arm_state", bus.state, 1);
    checkOutput("arm_busy", bus.busy, 1);
    bus.sb_mask = '0; bus.post_count = 16'd9; bus.pb_mode_req = 2'd1;
    applyStimulus(0, 0, 1);
    checkOutput("post_state", bus.state, 2);
    checkOutput("post_trig_cnt", bus.trig_cnt, 1);
    repeat (4) tick();
    checkOutput("post_edge5_freeze", bus.freeze, 0);
    checkOutput("post_edge5_state", bus.state, 2);
    tick();
    checkOutput("post_edge6_freeze", bus.freeze, 27'h7FFFFFF);
    checkOutput("post_edge6_state", bus.state, 3);
    checkOutput("frozen_busy", bus.busy, 0);
    checkOutput("pb_hold", bus.playback_mode, 2);

    // Trigger while frozen is a miss
    applyStimulus(0, 0, 1);
    checkOutput("frozen_miss", bus.miss_cnt, 1);
    checkOutput("frozen_hold", bus.freeze, 27'h7FFFFFF);

    // Re-arm from FROZEN drops freeze at once, keeps counters
    bus.sb_mask = 27'h00000A5; bus.post_count = 16'd0;
    applyStimulus(1, 0, 0);
    checkOutput("rearm_state", bus.state, 1);
    checkOutput("rearm_freeze", bus.freeze, 0);
    checkOutput("rearm_trig_keep", bus.trig_cnt, 1);

    // Zero post-count via external rising edge
    bus.trig_ext = 1'b1;
    tick();
    checkOutput("ext_state", bus.state, 3);
    checkOutput("ext_freeze", bus.freeze, 27'h00000A5);
    checkOutput("ext_trig_cnt", bus.trig_cnt, 2);
    tick();
    checkOutput("ext_level_no_miss", bus.miss_cnt, 1);
    bus.trig_ext = 1'b0;
    tick();

    // arm + release together while FROZEN: release wins
    applyStimulus(1, 1, 0);
    checkOutput("prio_state", bus.state, 0);
    checkOutput("prio_freeze", bus.freeze, 0);
    checkOutput("prio_trig_keep", bus.trig_cnt, 2);

    // Trigger in IDLE is ignored
    applyStimulus(0, 0, 1);
    checkOutput("idle_trig_cnt", bus.trig_cnt, 2);
    checkOutput("idle_miss_cnt", bus.miss_cnt, 1);
    checkOutput("idle_state", bus.state, 0);

    // Missed triggers during a long POST
    bus.pb_mode_req = 2'd3;
    bus.sb_mask = 27'h5555555; bus.post_count = 16'd100;
    applyStimulus(1, 0, 0);
    bus.pb_mode_req = 2'd0;
    checkOutput("arm2_clr_trig", bus.trig_cnt, 0);
    checkOutput("arm2_clr_miss", bus.miss_cnt, 0);
    checkOutput("arm2_pb", bus.playback_mode, 3);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    checkOutput("miss3", bus.miss_cnt, 3);
    checkOutput("miss3_trig", bus.trig_cnt, 1);
    repeat (96) tick();
    checkOutput("post100_edge100", bus.freeze, 0);
    tick();
    checkOutput("post100_edge101", bus.freeze, 27'h5555555);
    checkOutput("post100_pb_hold", bus.playback_mode, 3);

    // Release during POST: freeze never asserts
    applyStimulus(0, 1, 0);
    bus.sb_mask = 27'h00001FF; bus.post_count = 16'd10;
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    repeat (3) tick();
    applyStimulus(0, 1, 0);
    checkOutput("abort_state", bus.state, 0);
    checkOutput("abort_busy", bus.busy, 0);
    saw_freeze = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.freeze != '0) saw_freeze = 1'b1;
    end
    checkOutput("abort_no_freeze", saw_freeze, 0);

    // External level held high through reset and arm
    bus.trig_ext = 1'b1;
    rst_hs = 1'b1;
    tick();
    rst_hs = 1'b0;
    bus.sb_mask = 27'h0000003; bus.post_count = 16'd0;
    applyStimulus(1, 0, 0);
    repeat (3) tick();
    checkOutput("held_state", bus.state, 1);
    checkOutput("held_trig_cnt", bus.trig_cnt, 0);
    bus.trig_ext = 1'b0;
    tick();
    checkOutput("held_fall_state", bus.state, 1);
    bus.trig_ext = 1'b1;
    tick();
    checkOutput("held_rise_state", bus.state, 3);
    checkOutput("held_rise_freeze", bus.freeze, 3);

    // Asynchronous reset while FROZEN drops freeze before any edge
    #2 rst_hs = 1'b1;
    #1;
    checkOutput("async_frozen_freeze", bus.freeze, 0);
    checkOutput("async_frozen_state", bus.state, 0);
    rst_hs = 1'b0;
    tick();
    checkOutput("after_rst_idle", bus.state, 0);

    // Asynchronous reset mid-POST
    bus.trig_ext = 1'b0;
    bus.sb_mask = 27'h7FFFFFF; bus.post_count = 16'd50;
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    repeat (3) tick();
    checkOutput("midpost_state", bus.state, 2);
    #2 rst_hs = 1'b1;
    #1;
    checkOutput("midpost_rst_state", bus.state, 0);
    checkOutput("midpost_rst_busy", bus.busy, 0);
    checkOutput("midpost_rst_freeze", bus.freeze, 0);
    checkOutput("midpost_rst_pb", bus.playback_mode, 0);
    checkOutput("midpost_rst_trig", bus.trig_cnt, 0);
    checkOutput("midpost_rst_miss", bus.miss_cnt, 0);
    rst_hs = 1'b0;
    repeat (60) tick();
    checkOutput("midpost_no_pending", bus.freeze, 0);

    // Saturation on the 4-bit counter instance
    sif.sb_mask = 4'hF; sif.post_count = 4'd0;
    for (int i = 0; i < 20; i++) begin
      sif.arm = 1'b1;
      tick();
      sif.arm = 1'b0;
      sif.sw_trig = 1'b1;
      tick();
      sif.sw_trig = 1'b0;
      if (i == 13) checkOutput("sat_pre", sif.trig_cnt, 14);
    end
    checkOutput("sat_trig", sif.trig_cnt, 15);
    checkOutput("sat_miss", sif.miss_cnt, 0);
    checkOutput("sat_freeze", sif.freeze, 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
